// File: rtl/cda_seq_sub_if.sv
// Handshake/data bundle for the iterative subtractor cda_seq_sub.
// Optional feature macro: CDA_SUB_OVF_EN adds the signed-overflow flag ovf.
interface cda_seq_sub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef CDA_SUB_OVF_EN
    logic             ovf;
`endif

    // Producer of operands / consumer of results (ALU sequencer side)
    modport master (
        output in_valid, a, b, bin, out_ready,
`ifdef CDA_SUB_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, diff, bout
    );

    // The subtractor itself
    modport slave (
        input  in_valid, a, b, bin, out_ready,
`ifdef CDA_SUB_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/cda_seq_sub.sv
// Iterative multi-cycle subtractor: diff = a - b - bin, one GROUP_W slice per
// cycle, LSB slice first. Each slice subtracts with borrow-in 0 and is then
// decremented by the running borrow (inverse of the carry-increment adder).
// Optional feature macro: CDA_SUB_OVF_EN adds registered signed overflow ovf.
module cda_seq_sub #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned GROUP_W = 8
) (
    input logic          clk,
    input logic          rst,
    cda_seq_sub_if.slave bus
);
    localparam int unsigned NGRP  = WIDTH / GROUP_W;
    localparam int unsigned CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NGRP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
`ifdef CDA_SUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [GROUP_W-1:0] a_s, b_s;
    logic [GROUP_W:0]   sub_t, dec_t;
    logic               slice_borrow;
    logic               in_ready_w, out_valid_w;

    // Slice datapath: select slice cnt_q, subtract, then apply running borrow
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int unsigned k = 0; k < NGRP; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_s = a_q[k*GROUP_W +: GROUP_W];
                b_s = b_q[k*GROUP_W +: GROUP_W];
            end
        end
        sub_t = {1'b0, a_s} - {1'b0, b_s};
        dec_t = {1'b0, sub_t[GROUP_W-1:0]} - {{GROUP_W{1'b0}}, borrow_q};
        // A slice that borrowed leaves a nonzero low part, so the decrement
        // cannot borrow again; XOR equals OR here.
        slice_borrow = sub_t[GROUP_W] ^ dec_t[GROUP_W];
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        borrow_d    = borrow_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
`ifdef CDA_SUB_OVF_EN
        ovf_d       = ovf_q;
`endif
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_w = 1'b1;
                if (bus.in_valid && in_ready_w) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                for (int unsigned k = 0; k < NGRP; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        diff_d[k*GROUP_W +: GROUP_W] = dec_t[GROUP_W-1:0];
                    end
                end
                borrow_d = slice_borrow;
                if (cnt_q == LAST) begin
                    bout_d  = slice_borrow;
`ifdef CDA_SUB_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (dec_t[GROUP_W-1] != a_q[WIDTH-1]);
`endif
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                out_valid_w = 1'b1;
                if (out_valid_w && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef CDA_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef CDA_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
`ifdef CDA_SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule
